// File: rtl/iob_fifo_sync_fwft.sv
// rtl/iob_fifo_sync_fwft.sv - single-clock register-array FIFO with FWFT/standard read,
// level flags, sticky error flags and synchronous flush
module iob_fifo_sync_fwft #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int LEVEL_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cke_i,
  input  logic               clr_i,
  input  logic               w_en_i,
  input  logic [DATA_W-1:0]  w_data_i,
  output logic               w_full_o,
  output logic               almost_full_o,
  input  logic               r_en_i,
  output logic [DATA_W-1:0]  r_data_o,
  output logic               r_valid_o,
  output logic               r_empty_o,
  output logic               almost_empty_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] LVL_AF   = LEVEL_W'(AF_THRESH);
  localparam logic [LEVEL_W-1:0] LVL_AE   = LEVEL_W'(AE_THRESH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   w_ptr;
  logic [PTR_W-1:0]   r_ptr;
  logic [LEVEL_W-1:0] level;
  logic               w_acc;
  logic               r_acc;
  logic               advance;

  // Flags come only from the registered level, never from the request inputs.
  assign level_o        = level;
  assign w_full_o       = (level == LVL_FULL);
  assign r_empty_o      = (level == '0);
  assign almost_full_o  = (level >= LVL_AF);
  assign almost_empty_o = (level <= LVL_AE);

  assign w_acc   = w_en_i & ~w_full_o;
  assign r_acc   = r_en_i & ~r_empty_o;
  assign advance = rst_n_i & cke_i & ~clr_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (cke_i) begin
      if (clr_i) begin
        w_ptr       <= '0;
        r_ptr       <= '0;
        level       <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        if (w_acc) w_ptr <= ptr_inc(w_ptr);
        if (r_acc) r_ptr <= ptr_inc(r_ptr);
        case ({w_acc, r_acc})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (w_en_i && w_full_o)  overflow_o  <= 1'b1;
        if (r_en_i && r_empty_o) underflow_o <= 1'b1;
      end
    end
  end

  // Storage carries no reset; only words inside the live window are ever observed.
  always_ff @(posedge clk_i) begin
    if (advance && w_acc) mem[w_ptr] <= w_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data_o  = mem[r_ptr];
      assign r_valid_o = ~r_empty_o;
    end else begin : g_std
      logic [DATA_W-1:0] r_data_q;
      logic              r_valid_q;

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else if (cke_i) begin
          if (clr_i) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
          end else begin
            r_valid_q <= r_acc;
            if (r_acc) r_data_q <= mem[r_ptr];
          end
        end
      end

      assign r_data_o  = r_data_q;
      assign r_valid_o = r_valid_q;
    end
  endgenerate

endmodule
